ld_st_mem_ctrl: RTL and testbench

Data-side memory access controller that consumes the load/store size code (size_data_sel) and drives a 32-bit word-addressed memory bus with a req/ack handshake. For stores it places data on the correct byte lanes and generates byte enables. For loads it extracts the addressed bytes and applies sign or zero extension. Sits between the core's execute stage and the data memory port; misaligned accesses can optionally be split into two bus beats.

---
 rtl/ld_st_pkg.sv | 43 ++++
 rtl/ld_extend.sv | 22 ++
 rtl/ld_st_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ld_st_mem_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_st_pkg.sv
// Shared load/store definitions: size codes, controller states and byte-lane masks.
// Also used by the existing load/store decoder and any future load path.
package ld_st_pkg;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd3;
  localparam logic [2:0] SZ_HU = 3'd4;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_DONE
  } state_t;

  // Codes 5-7 fall into the default arm and behave as a word.
  function automatic logic [3:0] size_lanes(input logic [2:0] size);
    case (size)
      SZ_B, SZ_BU: return LANE_B;
      SZ_H, SZ_HU: return LANE_H;
      default:     return LANE_W;
    endcase
  endfunction

  function automatic logic [2:0] size_span(input logic [2:0] size);
    case (size)
      SZ_B, SZ_BU: return 3'd1;
      SZ_H, SZ_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] offset, input logic [2:0] size);
    return ({1'b0, offset} + size_span(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/ld_extend.sv
// Combinational load extension: sign- or zero-extends right-justified raw load data
// according to the load/store size code.
module ld_extend
  import ld_st_pkg::*;
(
  input  logic [2:0]  size_sel,
  input  logic [31:0] raw_data,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = raw_data;
    case (size_sel)
      SZ_B:    ext_data = {{24{raw_data[7]}}, raw_data[7:0]};
      SZ_BU:   ext_data = {24'h000000, raw_data[7:0]};
      SZ_H:    ext_data = {{16{raw_data[15]}}, raw_data[15:0]};
      SZ_HU:   ext_data = {16'h0000, raw_data[15:0]};
      default: ext_data = raw_data;
    endcase
  end

endmodule

// File: rtl/ld_st_mem_ctrl.sv
// Data-side load/store controller driving a word-addressed req/ack memory bus.
// Define LD_ST_MISALIGN_SPLIT_EN to split misaligned accesses into two beats.
module ld_st_mem_ctrl
  import ld_st_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [2:0]    size_data_sel,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_busy,
  output logic          core_done,
  output logic [DW-1:0] core_rdata,
  output logic          misalign_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state_q, state_d;
  logic          we_q;
  logic [2:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          misalign_q;
  logic          final_ack;
  logic [4:0]    lane_shift;
  logic [AW-1:0] word_addr;
  logic [DW-1:0] raw_data;
  logic [DW-1:0] ext_data;
  logic [3:0]    be_beat0;
  logic [DW-1:0] wdata_beat0;

  assign lane_shift = {addr_q[1:0], 3'b000};
  assign word_addr  = {addr_q[AW-1:2], 2'b00};

`ifdef LD_ST_MISALIGN_SPLIT_EN
  logic [DW-1:0]   rdata0_q;
  logic [7:0]      be_wide;
  logic [2*DW-1:0] wdata_wide;
  logic [2*DW-1:0] rdata_pair;

  // Shifting into a double-width window yields both beats' lanes at once.
  assign be_wide     = {4'b0000, size_lanes(size_q)} << addr_q[1:0];
  assign wdata_wide  = {{DW{1'b0}}, wdata_q} << lane_shift;
  assign be_beat0    = be_wide[3:0];
  assign wdata_beat0 = wdata_wide[DW-1:0];
  assign rdata_pair  = (state_q == ST_BEAT1) ? {mem_rdata, rdata0_q} : {{DW{1'b0}}, mem_rdata};
  assign raw_data    = DW'(rdata_pair >> lane_shift);
`else
  assign be_beat0    = size_lanes(size_q) << addr_q[1:0];
  assign wdata_beat0 = wdata_q << lane_shift;
  assign raw_data    = mem_rdata >> lane_shift;
`endif

  ld_extend u_ld_extend (
    .size_sel (size_q),
    .raw_data (raw_data),
    .ext_data (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= SZ_B;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
`ifdef LD_ST_MISALIGN_SPLIT_EN
      rdata0_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && core_req) begin
        we_q       <= core_we;
        size_q     <= size_data_sel;
        addr_q     <= core_addr;
        wdata_q    <= core_wdata;
        misalign_q <= is_misaligned(core_addr[1:0], size_data_sel);
      end
      if (final_ack && !we_q) begin
        rdata_q <= ext_data;
      end
`ifdef LD_ST_MISALIGN_SPLIT_EN
      if (state_q == ST_BEAT0 && mem_ack) begin
        rdata0_q <= mem_rdata;
      end
`endif
    end
  end

  // Next state and all bus/core outputs; everything idles at zero outside the beats.
  always_comb begin
    state_d      = state_q;
    final_ack    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_be       = 4'b0000;
    mem_wdata    = '0;
    core_done    = 1'b0;
    misalign_err = 1'b0;
    core_busy    = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (core_req) begin
`ifdef LD_ST_MISALIGN_SPLIT_EN
          state_d = ST_BEAT0;
`else
          state_d = is_misaligned(core_addr[1:0], size_data_sel) ? ST_DONE : ST_BEAT0;
`endif
        end
      end
      ST_BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_addr;
        mem_be    = be_beat0;
        mem_wdata = wdata_beat0;
        if (mem_ack) begin
`ifdef LD_ST_MISALIGN_SPLIT_EN
          state_d   = misalign_q ? ST_BEAT1 : ST_DONE;
          final_ack = !misalign_q;
`else
          state_d   = ST_DONE;
          final_ack = 1'b1;
`endif
        end
      end
`ifdef LD_ST_MISALIGN_SPLIT_EN
      ST_BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_addr + AW'(4);
        mem_be    = be_wide[7:4];
        mem_wdata = wdata_wide[2*DW-1:DW];
        if (mem_ack) begin
          state_d   = ST_DONE;
          final_ack = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        core_done = 1'b1;
`ifndef LD_ST_MISALIGN_SPLIT_EN
        misalign_err = misalign_q;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign core_rdata = rdata_q;

endmodule

// File: tb/tb_ld_st_mem_ctrl.sv
// Directed self-checking bench for ld_st_mem_ctrl; follows LD_ST_MISALIGN_SPLIT_EN
// so the same stimulus covers both the split and the error-reporting builds.
module tb_ld_st_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req;
  logic        core_we;
  logic [2:0]  size_data_sel;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_busy;
  logic        core_done;
  logic [31:0] core_rdata;
  logic        misalign_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  int          obs_beats;
  logic [31:0] obs_addr [2];
  logic [3:0]  obs_be [2];
  logic [31:0] obs_wdata [2];
  logic        obs_we, obs_held, obs_done, obs_err, obs_req_after;
  logic        obs_done_next, obs_busy_next;
  logic [31:0] obs_rdata;

  ld_st_mem_ctrl #(.AW(32), .DW(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_req      (core_req),
    .core_we       (core_we),
    .size_data_sel (size_data_sel),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_busy     (core_busy),
    .core_done     (core_done),
    .core_rdata    (core_rdata),
    .misalign_err  (misalign_err),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  // Issues one request, acknowledges each bus beat after the given wait count,
  // and records what the DUT presented; the callers do the checking.
  task automatic run_access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waits,
                            input logic [31:0] rd0, input logic [31:0] rd1);
    core_req = 1'b1; core_we = we; size_data_sel = sz; core_addr = addr; core_wdata = wdata;
    @(posedge clk); #1;
    core_req = 1'b0;
    obs_beats = 0; obs_held = 1'b1; obs_we = 1'b0;
    for (int b = 0; b < 2; b++) begin
      obs_addr[b] = '0; obs_be[b] = '0; obs_wdata[b] = '0;
    end
    while (mem_req && obs_beats < 2) begin
      obs_addr[obs_beats]  = mem_addr;
      obs_be[obs_beats]    = mem_be;
      obs_wdata[obs_beats] = mem_wdata;
      obs_we               = mem_we;
      repeat (waits) begin
        @(posedge clk); #1;
        if (!mem_req) obs_held = 1'b0;
      end
      mem_ack = 1'b1;
      mem_rdata = (obs_beats == 0) ? rd0 : rd1;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = '0;
      obs_beats++;
    end
    obs_done = core_done; obs_err = misalign_err; obs_rdata = core_rdata; obs_req_after = mem_req;
    @(posedge clk); #1;
    obs_done_next = core_done; obs_busy_next = core_busy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; size_data_sel = 3'd0;
    core_addr = '0; core_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #1;
    checks++; if (core_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", core_busy); end
    checks++; if (core_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", core_done); end
    checks++; if (core_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", core_rdata); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", misalign_err); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_be !== 4'h0) begin errors++; $display("[TB] FAIL reset_be: got %h expected 0", mem_be); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", mem_wdata); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_aligned_store;
    run_access(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0, 32'h0);
    checks++; if (obs_beats !== 1) begin errors++; $display("[TB] FAIL sw_beats: got %0d expected 1", obs_beats); end
    checks++; if (obs_addr[0] !== 32'h100) begin errors++; $display("[TB] FAIL sw_addr: got %h expected 00000100", obs_addr[0]); end
    checks++; if (obs_be[0] !== 4'hF) begin errors++; $display("[TB] FAIL sw_be: got %h expected f", obs_be[0]); end
    checks++; if (obs_wdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sw_wdata: got %h expected deadbeef", obs_wdata[0]); end
    checks++; if (obs_we !== 1'b1) begin errors++; $display("[TB] FAIL sw_we: got %b expected 1", obs_we); end
    checks++; if (obs_held !== 1'b1) begin errors++; $display("[TB] FAIL sw_req_held: got %b expected 1", obs_held); end
    checks++; if (obs_done !== 1'b1) begin errors++; $display("[TB] FAIL sw_done_after_ack: got %b expected 1", obs_done); end
    checks++; if (obs_req_after !== 1'b0) begin errors++; $display("[TB] FAIL sw_req_drop: got %b expected 0", obs_req_after); end
    checks++; if (obs_done_next !== 1'b0) begin errors++; $display("[TB] FAIL sw_done_width: got %b expected 0", obs_done_next); end
    checks++; if (obs_busy_next !== 1'b0) begin errors++; $display("[TB] FAIL sw_idle: got %b expected 0", obs_busy_next); end
    checks++; if (obs_rdata !== 32'h0) begin errors++; $display("[TB] FAIL sw_rdata_hold: got %h expected 0", obs_rdata); end

    run_access(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 0, 32'h0, 32'h0);
    checks++; if (obs_beats !== 1) begin errors++; $display("[TB] FAIL sb_beats: got %0d expected 1", obs_beats); end
    checks++; if (obs_addr[0] !== 32'h100) begin errors++; $display("[TB] FAIL sb_addr: got %h expected 00000100", obs_addr[0]); end
    checks++; if (obs_be[0] !== 4'b1000) begin errors++; $display("[TB] FAIL sb_be: got %b expected 1000", obs_be[0]); end
    checks++; if (obs_wdata[0] !== 32'hA500_0000) begin errors++; $display("[TB] FAIL sb_wdata: got %h expected a5000000", obs_wdata[0]); end
    checks++; if (obs_done !== 1'b1) begin errors++; $display("[TB] FAIL sb_done: got %b expected 1", obs_done); end
  endtask

  task automatic test_loads;
    run_access(1'b0, 3'd0, 32'h0000_0102, 32'h0, 0, 32'h0080_0000, 32'h0);
    checks++; if (obs_rdata !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL lb_rdata: got %h expected ffffff80", obs_rdata); end
    checks++; if (obs_be[0] !== 4'b0100) begin errors++; $display("[TB] FAIL lb_be: got %b expected 0100", obs_be[0]); end
    checks++; if (obs_we !== 1'b0) begin errors++; $display("[TB] FAIL lb_we: got %b expected 0", obs_we); end
    checks++; if (obs_done !== 1'b1) begin errors++; $display("[TB] FAIL lb_done: got %b expected 1", obs_done); end

    run_access(1'b0, 3'd3, 32'h0000_0102, 32'h0, 1, 32'h0080_0000, 32'h0);
    checks++; if (obs_rdata !== 32'h0000_0080) begin errors++; $display("[TB] FAIL lbu_rdata: got %h expected 00000080", obs_rdata); end

    run_access(1'b0, 3'd4, 32'h0000_0102, 32'h0, 0, 32'h8001_0000, 32'h0);
    checks++; if (obs_rdata !== 32'h0000_8001) begin errors++; $display("[TB] FAIL lhu_rdata: got %h expected 00008001", obs_rdata); end
    checks++; if (obs_be[0] !== 4'b1100) begin errors++; $display("[TB] FAIL lhu_be: got %b expected 1100", obs_be[0]); end

    run_access(1'b0, 3'd1, 32'h0000_0102, 32'h0, 0, 32'h8001_0000, 32'h0);
    checks++; if (obs_rdata !== 32'hFFFF_8001) begin errors++; $display("[TB] FAIL lh_rdata: got %h expected ffff8001", obs_rdata); end

    run_access(1'b0, 3'd1, 32'h0000_0101, 32'h0, 0, 32'h00AB_CD00, 32'h0);
    checks++; if (obs_beats !== 1) begin errors++; $display("[TB] FAIL lh_off1_beats: got %0d expected 1", obs_beats); end
    checks++; if (obs_be[0] !== 4'b0110) begin errors++; $display("[TB] FAIL lh_off1_be: got %b expected 0110", obs_be[0]); end
    checks++; if (obs_rdata !== 32'hFFFF_ABCD) begin errors++; $display("[TB] FAIL lh_off1_rdata: got %h expected ffffabcd", obs_rdata); end

    run_access(1'b0, 3'd2, 32'h0000_0108, 32'h0, 0, 32'h7654_3210, 32'h0);
    checks++; if (obs_rdata !== 32'h7654_3210) begin errors++; $display("[TB] FAIL lw_rdata: got %h expected 76543210", obs_rdata); end
    checks++; if (obs_addr[0] !== 32'h108) begin errors++; $display("[TB] FAIL lw_addr: got %h expected 00000108", obs_addr[0]); end

    run_access(1'b1, 3'd2, 32'h0000_0200, 32'h1111_2222, 0, 32'hFFFF_FFFF, 32'h0);
    checks++; if (obs_rdata !== 32'h7654_3210) begin errors++; $display("[TB] FAIL store_keeps_rdata: got %h expected 76543210", obs_rdata); end
  endtask

  task automatic test_misaligned;
    run_access(1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, 0, 32'h3344_0000, 32'h0000_1122);
`ifdef LD_ST_MISALIGN_SPLIT_EN
    checks++; if (obs_beats !== 2) begin errors++; $display("[TB] FAIL split_lw_beats: got %0d expected 2", obs_beats); end
    checks++; if (obs_addr[0] !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL split_lw_addr0: got %h expected fffffffc", obs_addr[0]); end
    checks++; if (obs_addr[1] !== 32'h0) begin errors++; $display("[TB] FAIL split_lw_addr1: got %h expected 00000000", obs_addr[1]); end
    checks++; if (obs_be[0] !== 4'b1100) begin errors++; $display("[TB] FAIL split_lw_be0: got %b expected 1100", obs_be[0]); end
    checks++; if (obs_be[1] !== 4'b0011) begin errors++; $display("[TB] FAIL split_lw_be1: got %b expected 0011", obs_be[1]); end
    checks++; if (obs_rdata !== 32'h1122_3344) begin errors++; $display("[TB] FAIL split_lw_rdata: got %h expected 11223344", obs_rdata); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("[TB] FAIL split_lw_err: got %b expected 0", obs_err); end
    checks++; if (obs_done !== 1'b1) begin errors++; $display("[TB] FAIL split_lw_done: got %b expected 1", obs_done); end

    run_access(1'b1, 3'd1, 32'h0000_0103, 32'h0000_1234, 1, 32'h0, 32'h0);
    checks++; if (obs_beats !== 2) begin errors++; $display("[TB] FAIL split_sh_beats: got %0d expected 2", obs_beats); end
    checks++; if (obs_be[0] !== 4'b1000) begin errors++; $display("[TB] FAIL split_sh_be0: got %b expected 1000", obs_be[0]); end
    checks++; if (obs_wdata[0] !== 32'h3400_0000) begin errors++; $display("[TB] FAIL split_sh_wdata0: got %h expected 34000000", obs_wdata[0]); end
    checks++; if (obs_addr[1] !== 32'h104) begin errors++; $display("[TB] FAIL split_sh_addr1: got %h expected 00000104", obs_addr[1]); end
    checks++; if (obs_be[1] !== 4'b0001) begin errors++; $display("[TB] FAIL split_sh_be1: got %b expected 0001", obs_be[1]); end
    checks++; if (obs_wdata[1] !== 32'h0000_0012) begin errors++; $display("[TB] FAIL split_sh_wdata1: got %h expected 00000012", obs_wdata[1]); end
    checks++; if (obs_rdata !== 32'h1122_3344) begin errors++; $display("[TB] FAIL split_sh_rdata_hold: got %h expected 11223344", obs_rdata); end
`else
    checks++; if (obs_beats !== 0) begin errors++; $display("[TB] FAIL mis_lw_beats: got %0d expected 0", obs_beats); end
    checks++; if (obs_done !== 1'b1) begin errors++; $display("[TB] FAIL mis_lw_done: got %b expected 1", obs_done); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_lw_err: got %b expected 1", obs_err); end
    checks++; if (obs_req_after !== 1'b0) begin errors++; $display("[TB] FAIL mis_lw_req: got %b expected 0", obs_req_after); end
    checks++; if (obs_rdata !== 32'h7654_3210) begin errors++; $display("[TB] FAIL mis_lw_rdata_hold: got %h expected 76543210", obs_rdata); end
    checks++; if (obs_busy_next !== 1'b0) begin errors++; $display("[TB] FAIL mis_lw_idle: got %b expected 0", obs_busy_next); end

    run_access(1'b1, 3'd1, 32'h0000_0103, 32'h0000_1234, 0, 32'h0, 32'h0);
    checks++; if (obs_beats !== 0) begin errors++; $display("[TB] FAIL mis_sh_beats: got %0d expected 0", obs_beats); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_sh_err: got %b expected 1", obs_err); end
    checks++; if (obs_done_next !== 1'b0) begin errors++; $display("[TB] FAIL mis_sh_done_width: got %b expected 0", obs_done_next); end
`endif
  endtask

  task automatic test_reset_mid;
    core_req = 1'b1; core_we = 1'b0; size_data_sel = 3'd2; core_addr = 32'h40; core_wdata = '0;
    @(posedge clk); #1;
    core_req = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_req_before: got %b expected 1", mem_req); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_req_cleared: got %b expected 0", mem_req); end
    checks++; if (core_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy_cleared: got %b expected 0", core_busy); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL mid_addr_cleared: got %h expected 0", mem_addr); end
    checks++; if (mem_be !== 4'h0) begin errors++; $display("[TB] FAIL mid_be_cleared: got %h expected 0", mem_be); end
    checks++; if (core_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_rdata_cleared: got %h expected 0", core_rdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (core_done !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack_done: got %b expected 0", core_done); end
    checks++; if (core_busy !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack_busy: got %b expected 0", core_busy); end
    checks++; if (core_rdata !== 32'h0) begin errors++; $display("[TB] FAIL stray_ack_rdata: got %h expected 0", core_rdata); end

    run_access(1'b0, 3'd2, 32'h0000_0044, 32'h0, 0, 32'hCAFE_F00D, 32'h0);
    checks++; if (obs_addr[0] !== 32'h44) begin errors++; $display("[TB] FAIL post_reset_addr: got %h expected 00000044", obs_addr[0]); end
    checks++; if (obs_rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL post_reset_rdata: got %h expected cafef00d", obs_rdata); end
  endtask

  task automatic test_back_to_back;
    core_req = 1'b1; core_we = 1'b1; size_data_sel = 3'd7; core_addr = 32'h300; core_wdata = 32'h0102_0304;
    @(posedge clk); #1;
    checks++; if (mem_be !== 4'hF) begin errors++; $display("[TB] FAIL code7_be: got %h expected f", mem_be); end
    checks++; if (mem_addr !== 32'h300) begin errors++; $display("[TB] FAIL b2b_addr0: got %h expected 00000300", mem_addr); end
    checks++; if (mem_wdata !== 32'h0102_0304) begin errors++; $display("[TB] FAIL code7_wdata: got %h expected 01020304", mem_wdata); end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++; if (core_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done0: got %b expected 1", core_done); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_req_in_done: got %b expected 0", mem_req); end
    core_addr = 32'h304;
    @(posedge clk); #1;
    checks++; if (core_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap: got %b expected 0", core_busy); end
    @(posedge clk); #1;
    core_req = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL b2b_req1: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h304) begin errors++; $display("[TB] FAIL b2b_addr1: got %h expected 00000304", mem_addr); end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++; if (core_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done1: got %b expected 1", core_done); end
    @(posedge clk); #1;
    checks++; if (core_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_final_idle: got %b expected 0", core_busy); end
  endtask

  initial begin
    test_reset;
    test_aligned_store;
    test_loads;
    test_misaligned;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
